cpu_bus_sequencer: RTL
======================

# cpu_bus_sequencer

Parametrised bus-master sequencer that drives a 6502-style CPU bus (address, data, active-low write enable) in 65C02 cycle timing, fed by a queue of read/write commands rather than blocking tasks. It watches the PHI2 clock in the FPGA system clock domain and launches one bus cycle per PHI2 period. It delays output transitions a configurable number of system clocks after the PHI2 falling edge. It returns read data through a valid/ready response port. It sits in the simulation and bring-up harness wherever a CPU bus master is needed: bench stimulus, or a scripted stand-in for the CPU on hardware.

## Interface
Parameters:
- ADDR_WIDTH, default CPU_ADDR_WIDTH (16): bus address width.
- DATA_WIDTH, default DATA_WIDTH (8): bus data width.
- CMD_DEPTH, default 4: command FIFO entries; power of two, ≥2.
- HOLD_DELAY, default 1: system clocks from PHI2-fall detection to output update; range 1..15.

Ports:
- sys_clock_i  in  1  FPGA system clock; the only clock.
- reset_i  in  1  asynchronous, active-high reset.
- cpu_clock_i  in  1  PHI2, generated synchronously to sys_clock_i.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  FIFO not full.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  command address.
- cmd_data_i  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid_o  out  1  read data available.
- rsp_ready_i  in  1  response consumed.
- rsp_data_o  out  DATA_WIDTH  captured read data.
- addr_o  out  ADDR_WIDTH  bus address.
- data_o  out  DATA_WIDTH  bus write data.
- we_n_o  out  1  bus write enable, active low.
- data_i  in  DATA_WIDTH  bus read data.
- ready_i  in  1  RDY wait-state input, active high.
- busy_o  out  1  FIFO non-empty or bus cycle in progress.

## Operation
- clk_q registers cpu_clock_i.
  - ne = clk_q & ~cpu_clock_i.
  - pe = ~clk_q & cpu_clock_i.
- Handshake: a push occurs on any edge with cmd_valid_i & cmd_ready_o.
  - cmd_ready_o = ~full, taken from the registered count.
  - There is no same-cycle bypass on full.
- FSM states: IDLE, HOLD, ACTIVE, STRETCH.
- IDLE, on ne: decide the launch, load the hold counter with HOLD_DELAY-1, go to HOLD.
  - Launch if the FIFO is non-empty and the head is not a read while rsp_valid_o=1. Pop the head.
  - Otherwise launch an idle cycle: we_n_o=1, addr_o and data_o held.
- HOLD: counter reaches 0 → drive addr_o, data_o, we_n_o from the latched command; go to ACTIVE.
- ACTIVE, on pe:
  - ready_i=1 or write: cycle completes. A read captures data_i into rsp_data_o, with rsp_valid_o=1 on the next edge. Go to IDLE.
  - ready_i=0 and read: go to STRETCH; outputs held.
- STRETCH: ignores ne and re-evaluates at each pe as in ACTIVE.
- Write cycles do not stretch (65C02 RDY semantics).
- rsp_valid_o clears on the edge with rsp_ready_i=1.
- Reset values:
  - addr_o=0, data_o=0, we_n_o=1.
  - rsp_valid_o=0, rsp_data_o=0, busy_o=0, cmd_ready_o=1.
  - FIFO empty, FSM IDLE, clk_q=0.
- Asserting reset mid-operation aborts immediately: FIFO flushed, pending response dropped, outputs at reset values.

## Timing
- ne/pe are detected one sys edge after the PHI2 transition is sampled.
- Output latency: outputs change exactly HOLD_DELAY sys edges after the edge at which ne is first high. The edge at which ne is first high is edge 0.
- A command pushed on or before the ne edge can launch in that cycle.
- Read response latency: rsp_valid_o rises one sys edge after the completing pe.
- Throughput: one command per PHI2 period plus stretch periods.
- ne must not recur before HOLD expires. The integrator must keep HOLD_DELAY below the PHI2 low phase; this is not checked in RTL.

## Configuration
- CPU_BUS_SEQ_RDY_EN defined: ready_i is honoured and the STRETCH state exists.
- CPU_BUS_SEQ_RDY_EN undefined: ready_i is ignored and every read completes at its first pe.

## Structure
- common_pkg holds:
  - CPU_ADDR_WIDTH and DATA_WIDTH, used as parameter defaults.
  - typedef bus_cmd_t {we, addr, data}.
  - typedef seq_state_t enum {IDLE, HOLD, ACTIVE, STRETCH}.
- One sub-module: sync_fifo (WIDTH, DEPTH), with push/pop, full/empty and an asynchronous active-high reset. The command FIFO instantiates it.

## Test plan
- Reset, then push write 0x8000←0x5A with HOLD_DELAY=1 → at the first PHI2 fall, addr_o=0x8000, data_o=0x5A, we_n_o=0 one sys edge after ne; we_n_o=1 in the next cycle.
- Push read 0xE810 with data_i=0xA5 at PHI2 rise → rsp_valid_o=1, rsp_data_o=0xA5 one edge after pe; rsp_ready_i clears it.
- HOLD_DELAY=3 → outputs change on the 3rd sys edge after ne; not before.
- Push 5 commands back-to-back (CMD_DEPTH=4) → cmd_ready_o=0 after 4. Cycles issue in order, one per PHI2 period.
- Two reads with rsp_ready_i=0 → the second read stalls as idle cycles (we_n_o=1) until the first response is taken. With RDY_EN, ready_i=0 for 2 pe's → the read stretches 2 periods and captures data on the third.
- Assert reset_i in HOLD → outputs are at reset values asynchronously; after release, busy_o=0 and cmd_ready_o=1.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types and default widths for the CPU bus sequencer slice.
//   CPU_ADDR_WIDTH / DATA_WIDTH : default bus widths, used as parameter defaults.
//   bus_cmd_t                   : one queued bus command {we, addr, data}.
//   seq_state_t                 : bus-cycle FSM states.
//   HOLD_CNT_W                  : width of the post-PHI2-fall hold counter (HOLD_DELAY <= 15).
package common_pkg;

  localparam int unsigned CPU_ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned HOLD_CNT_W     = 4;

  typedef struct packed {
    logic                      we;
    logic [CPU_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    ACTIVE,
    STRETCH
  } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset, empties the FIFO
//   push_i    : write wdata_i (ignored when full)
//   pop_i     : discard the head entry (ignored when empty)
//   wdata_i   : write data
//   rdata_o   : head entry, valid while empty_o is low
//   full_o    : DEPTH entries held
//   empty_o   : no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// Queue-fed 6502/65C02-style bus master. Commands (read/write) are buffered in a
// FIFO and issued one per PHI2 period; bus outputs update HOLD_DELAY system
// clocks after the PHI2 falling edge is detected, read data is sampled at the
// PHI2 rising edge and returned through a valid/ready response port.
//
// Ports:
//   sys_clock_i  : FPGA system clock (only clock)
//   reset_i      : asynchronous active-high reset
//   cpu_clock_i  : PHI2, synchronous to sys_clock_i
//   cmd_*        : command push port (valid/ready), we=1 write, we=0 read
//   rsp_*        : read response port (valid/ready)
//   addr_o/data_o/we_n_o : bus outputs, we_n_o active low
//   data_i       : bus read data
//   ready_i      : RDY wait-state input, active high
//   busy_o       : commands queued or a command bus cycle in flight
//
// Build option: define CPU_BUS_SEQ_RDY_EN to honour ready_i (read cycles
// stretch while RDY is low). Without it ready_i is ignored.
module cpu_bus_sequencer #(
  parameter int unsigned ADDR_WIDTH = common_pkg::CPU_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = common_pkg::DATA_WIDTH,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned HOLD_DELAY = 1
) (
  input  logic                  sys_clock_i,
  input  logic                  reset_i,
  input  logic                  cpu_clock_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  we_n_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  busy_o
);

  import common_pkg::*;

  localparam int unsigned CmdW = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [HOLD_CNT_W-1:0] HoldLoad = HOLD_CNT_W'(HOLD_DELAY - 1);

  // PHI2 edge detection
  logic clk_q;
  logic ne, pe;

  assign ne = clk_q & ~cpu_clock_i;
  assign pe = ~clk_q & cpu_clock_i;

  // Command FIFO
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CmdW-1:0] fifo_rdata, cmd_word;
  logic            push_req;

  assign cmd_word    = {cmd_we_i, cmd_addr_i, cmd_data_i};
  assign push_req    = cmd_valid_i & ~fifo_full;
  assign cmd_ready_o = ~fifo_full;

  sync_fifo #(
    .WIDTH (CmdW),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (sys_clock_i),
    .rst_i   (reset_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (cmd_word),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State
  seq_state_t            state_q, state_d;
  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
  logic [CmdW-1:0]       lat_q, lat_d;
  logic                  lat_idle_q, lat_idle_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  we_n_q, we_n_d;
  logic                  cap_q, cap_d;
  logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;

  assign lat_we   = lat_q[CmdW-1];
  assign lat_addr = lat_q[CmdW-2 -: ADDR_WIDTH];
  assign lat_data = lat_q[DATA_WIDTH-1:0];

  // Launch decision. An empty FIFO lets a command arriving on the ne edge
  // launch directly instead of waiting a whole PHI2 period.
  logic [CmdW-1:0] head_word;
  logic            head_avail, head_we, rsp_block, launch;

  assign head_word  = fifo_empty ? cmd_word : fifo_rdata;
  assign head_avail = ~fifo_empty | push_req;
  assign head_we    = head_word[CmdW-1];
  // cap_q covers the edge between read capture and rsp_valid_o rising.
  assign rsp_block  = rsp_valid_q | cap_q;
  assign launch     = (state_q == IDLE) & ne & head_avail & (head_we | ~rsp_block);
  assign fifo_pop   = launch & ~fifo_empty;
  assign fifo_push  = push_req & ~(launch & fifo_empty);

  // Only real read cycles can be stretched; writes and idle cycles never wait.
  logic stretch_req;
`ifdef CPU_BUS_SEQ_RDY_EN
  assign stretch_req = ~ready_i & ~lat_idle_q & ~lat_we;
`else
  logic unused_ready;
  assign unused_ready = ready_i;
  assign stretch_req  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    lat_idle_d  = lat_idle_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_n_d      = we_n_q;
    cap_d       = 1'b0;
    cap_data_d  = cap_data_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ready_i;
    rsp_data_d  = rsp_data_q;

    // Captured read data surfaces one edge after the completing pe.
    if (cap_q) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = cap_data_q;
    end

    case (state_q)
      IDLE: begin
        if (ne) begin
          cnt_d      = HoldLoad;
          lat_idle_d = ~launch;
          if (launch) lat_d = head_word;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (lat_idle_q) begin
            we_n_d = 1'b1;
          end else begin
            addr_d = lat_addr;
            data_d = lat_data;
            we_n_d = ~lat_we;
          end
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - HOLD_CNT_W'(1);
        end
      end
      ACTIVE, STRETCH: begin
        if (pe) begin
          if (stretch_req) begin
            state_d = STRETCH;
          end else begin
            state_d = IDLE;
            if (!lat_idle_q && !lat_we) begin
              cap_d      = 1'b1;
              cap_data_d = data_i;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock_i or posedge reset_i) begin
    if (reset_i) begin
      clk_q       <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_q       <= '0;
      lat_idle_q  <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      we_n_q      <= 1'b1;
      cap_q       <= 1'b0;
      cap_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      clk_q       <= cpu_clock_i;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      lat_idle_q  <= lat_idle_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_n_q      <= we_n_d;
      cap_q       <= cap_d;
      cap_data_q  <= cap_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign we_n_o      = we_n_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = ~fifo_empty | ((state_q != IDLE) & ~lat_idle_q);

endmodule
